// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared constants and operand-select encoding for the EX stage
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_ZERO,
        FWD_EXMEM,
        FWD_MEMWB,
        FWD_RF
    } fwd_sel_e;

endpackage

// File: rtl/bypass_mux.sv
// rtl/bypass_mux.sv - per-operand priority select between x0, EX/MEM, MEM/WB and register file
module bypass_mux #(
    parameter int XLEN = 32
) (
    input  logic [4:0]      idx,
    input  logic            fwd_ex,
    input  logic            fwd_mem,
    input  logic            exmem_v,
    input  logic            exmem_load,
    input  logic            memwb_v,
    input  logic [XLEN-1:0] ex_mem_result,
    input  logic [XLEN-1:0] mem_wb_result,
    input  logic [XLEN-1:0] rf_data,
    output logic [XLEN-1:0] operand,
    output logic            forwarded
);
    import core_pkg::*;

    fwd_sel_e sel;

    // A load in EX/MEM only holds its address, so it must never be bypassed.
    always_comb begin
        if (idx == REG_ZERO) begin
            sel = FWD_ZERO;
        end else if (fwd_ex && exmem_v && !exmem_load) begin
            sel = FWD_EXMEM;
        end else if (fwd_mem && memwb_v) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_RF;
        end
    end

    always_comb begin
        operand = '0;
        case (sel)
            FWD_ZERO:  operand = '0;
            FWD_EXMEM: operand = ex_mem_result;
            FWD_MEMWB: operand = mem_wb_result;
            FWD_RF:    operand = rf_data;
            default:   operand = rf_data;
        endcase
    end

    assign forwarded = (sel == FWD_EXMEM) || (sel == FWD_MEMWB);

endmodule

// File: rtl/ex_operand_bypass.sv
// rtl/ex_operand_bypass.sv - EX operand forwarding, result pipeline registers and hazard counters
module ex_operand_bypass #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             fwd_ex_ex1,
    input  logic             fwd_ex_ex2,
    input  logic             fwd_mem_ex1,
    input  logic             fwd_mem_ex2,
    input  logic             id_valid,
    input  logic [4:0]       rs1_idx,
    input  logic [4:0]       rs2_idx,
    input  logic [XLEN-1:0]  rf_rs1_data,
    input  logic [XLEN-1:0]  rf_rs2_data,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             ex_writes_rd,
    input  logic             ex_is_load,
    input  logic [XLEN-1:0]  mem_load_data,
    output logic [XLEN-1:0]  op1,
    output logic [XLEN-1:0]  op2,
    output logic             ex_valid,
    output logic [XLEN-1:0]  wb_data,
    output logic             wb_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] fwd_cnt
);

    logic            exmem_v;
    logic            exmem_load;
    logic            memwb_v;
    logic [XLEN-1:0] ex_mem_result;
    logic [XLEN-1:0] mem_wb_result;
    logic            fwd1_used;
    logic            fwd2_used;

    bypass_mux #(.XLEN(XLEN)) u_mux1 (
        .idx           (rs1_idx),
        .fwd_ex        (fwd_ex_ex1),
        .fwd_mem       (fwd_mem_ex1),
        .exmem_v       (exmem_v),
        .exmem_load    (exmem_load),
        .memwb_v       (memwb_v),
        .ex_mem_result (ex_mem_result),
        .mem_wb_result (mem_wb_result),
        .rf_data       (rf_rs1_data),
        .operand       (op1),
        .forwarded     (fwd1_used)
    );

    bypass_mux #(.XLEN(XLEN)) u_mux2 (
        .idx           (rs2_idx),
        .fwd_ex        (fwd_ex_ex2),
        .fwd_mem       (fwd_mem_ex2),
        .exmem_v       (exmem_v),
        .exmem_load    (exmem_load),
        .memwb_v       (memwb_v),
        .ex_mem_result (ex_mem_result),
        .mem_wb_result (mem_wb_result),
        .rf_data       (rf_rs2_data),
        .operand       (op2),
        .forwarded     (fwd2_used)
    );

    // Valid chain: a stall turns the ID instruction into a single EX bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid      <= 1'b0;
            exmem_v       <= 1'b0;
            memwb_v       <= 1'b0;
            exmem_load    <= 1'b0;
            ex_mem_result <= '0;
            mem_wb_result <= '0;
        end else begin
            ex_valid      <= id_valid & ~stall;
            exmem_v       <= ex_valid & ex_writes_rd;
            memwb_v       <= exmem_v;
            exmem_load    <= ex_is_load;
            ex_mem_result <= alu_result;
            mem_wb_result <= exmem_load ? mem_load_data : ex_mem_result;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (ex_valid && (fwd1_used || fwd2_used) && (fwd_cnt != {CNT_W{1'b1}})) begin
                fwd_cnt <= fwd_cnt + CNT_W'(1);
            end
        end
    end

    assign wb_data  = mem_wb_result;
    assign wb_valid = memwb_v;

endmodule

// File: tb/tb_ex_operand_bypass.sv
// tb/tb_ex_operand_bypass.sv - self-checking bench for ex_operand_bypass
module tb_ex_operand_bypass;

    localparam int XLEN  = 32;
    localparam int CNT_W = 3;

    logic             clk;
    logic             rst;
    logic             stall;
    logic             fwd_ex_ex1;
    logic             fwd_ex_ex2;
    logic             fwd_mem_ex1;
    logic             fwd_mem_ex2;
    logic             id_valid;
    logic [4:0]       rs1_idx;
    logic [4:0]       rs2_idx;
    logic [XLEN-1:0]  rf_rs1_data;
    logic [XLEN-1:0]  rf_rs2_data;
    logic [XLEN-1:0]  alu_result;
    logic             ex_writes_rd;
    logic             ex_is_load;
    logic [XLEN-1:0]  mem_load_data;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic             ex_valid;
    logic [XLEN-1:0]  wb_data;
    logic             wb_valid;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] fwd_cnt;

    ex_operand_bypass #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .fwd_ex_ex1    (fwd_ex_ex1),
        .fwd_ex_ex2    (fwd_ex_ex2),
        .fwd_mem_ex1   (fwd_mem_ex1),
        .fwd_mem_ex2   (fwd_mem_ex2),
        .id_valid      (id_valid),
        .rs1_idx       (rs1_idx),
        .rs2_idx       (rs2_idx),
        .rf_rs1_data   (rf_rs1_data),
        .rf_rs2_data   (rf_rs2_data),
        .alu_result    (alu_result),
        .ex_writes_rd  (ex_writes_rd),
        .ex_is_load    (ex_is_load),
        .mem_load_data (mem_load_data),
        .op1           (op1),
        .op2           (op2),
        .ex_valid      (ex_valid),
        .wb_data       (wb_data),
        .wb_valid      (wb_valid),
        .stall_cnt     (stall_cnt),
        .fwd_cnt       (fwd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        id_valid;
        logic        stall;
        logic        fe1;
        logic        fe2;
        logic        fm1;
        logic        fm2;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rf1;
        logic [31:0] rf2;
        logic [31:0] alu;
        logic        wr;
        logic        ld;
        logic [31:0] mld;
        logic [31:0] exp_op1;
        logic [31:0] exp_op2;
        logic        exp_exv;
        int          exp_stall;
        int          exp_fwd;
    } vec_t;

    localparam int NV = 11;
    vec_t        tbl [NV];
    logic [31:0] wb_q [$];
    logic [31:0] wb_exp;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        stall = 0; fwd_ex_ex1 = 0; fwd_ex_ex2 = 0; fwd_mem_ex1 = 0; fwd_mem_ex2 = 0;
        id_valid = 0; rs1_idx = 0; rs2_idx = 0; rf_rs1_data = 0; rf_rs2_data = 0;
        alu_result = 0; ex_writes_rd = 0; ex_is_load = 0; mem_load_data = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // id,st,fe1,fe2,fm1,fm2, rs1,rs2, rf1,rf2, alu, wr,ld, mld, op1,op2, exv, stall_cnt, fwd_cnt
        tbl[0]  = '{1,0,0,0,0,0,  1, 2, 'h100,'h200, 'h00, 0,0, 'h0,        'h100,'h200,        0, 0, 0};
        tbl[1]  = '{1,0,0,0,0,0,  3, 4, 'h101,'h201, 'h15, 1,0, 'h0,        'h101,'h201,        1, 0, 0};
        tbl[2]  = '{1,0,1,0,0,0,  5, 6, 'h000,'h202, 'h22, 1,1, 'h0,        'h015,'h202,        1, 0, 0};
        tbl[3]  = '{1,0,1,1,0,1,  7, 8, 'h103,'h203, 'h33, 1,0, 'hDEADBEEF, 'h103,'h015,        1, 0, 1};
        tbl[4]  = '{1,1,1,0,1,1, 10, 9, 'h104,'h204, 'h44, 1,0, 'h0,        'h033,'hDEADBEEF,   1, 0, 2};
        tbl[5]  = '{1,0,1,1,0,0,  0,11, 'h105,'h205, 'h99, 1,0, 'h0,        'h000,'h044,        0, 1, 3};
        tbl[6]  = '{1,0,1,0,0,1, 12, 0, 'h106,'h206, 'h66, 1,0, 'h0,        'h106,'h000,        1, 1, 3};
        tbl[7]  = '{0,0,0,1,1,0, 13,14, 'h107,'h207, 'h77, 1,0, 'h0,        'h107,'h066,        1, 1, 3};
        tbl[8]  = '{0,0,0,0,0,0,  1, 2, 'h108,'h208, 'h00, 0,0, 'h0,        'h108,'h208,        0, 1, 4};
        tbl[9]  = '{0,0,0,0,0,0,  1, 2, 'h109,'h209, 'h00, 0,0, 'h0,        'h109,'h209,        0, 1, 4};
        tbl[10] = '{0,0,0,0,0,0,  1, 2, 'h10A,'h20A, 'h00, 0,0, 'h0,        'h10A,'h20A,        0, 1, 4};

        drive_idle();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        chk("reset_ex_valid", 32'(ex_valid), 32'd0);
        chk("reset_wb_valid", 32'(wb_valid), 32'd0);
        chk("reset_wb_data", wb_data, 32'd0);
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_fwd_cnt", 32'(fwd_cnt), 32'd0);

        for (int r = 0; r < NV; r++) begin
            id_valid = tbl[r].id_valid; stall = tbl[r].stall;
            fwd_ex_ex1 = tbl[r].fe1; fwd_ex_ex2 = tbl[r].fe2;
            fwd_mem_ex1 = tbl[r].fm1; fwd_mem_ex2 = tbl[r].fm2;
            rs1_idx = tbl[r].rs1; rs2_idx = tbl[r].rs2;
            rf_rs1_data = tbl[r].rf1; rf_rs2_data = tbl[r].rf2;
            alu_result = tbl[r].alu; ex_writes_rd = tbl[r].wr;
            ex_is_load = tbl[r].ld; mem_load_data = tbl[r].mld;
            @(negedge clk);
            chk($sformatf("row%0d_op1", r), op1, tbl[r].exp_op1);
            chk($sformatf("row%0d_op2", r), op2, tbl[r].exp_op2);
            chk($sformatf("row%0d_ex_valid", r), 32'(ex_valid), 32'(tbl[r].exp_exv));
            chk($sformatf("row%0d_stall_cnt", r), 32'(stall_cnt), 32'(tbl[r].exp_stall));
            chk($sformatf("row%0d_fwd_cnt", r), 32'(fwd_cnt), 32'(tbl[r].exp_fwd));
            // Loads write back the data returned one cycle after they leave EX.
            if (tbl[r].exp_exv && tbl[r].wr) begin
                if (tbl[r].ld && (r + 1 < NV)) wb_q.push_back(tbl[r + 1].mld);
                else wb_q.push_back(tbl[r].alu);
            end
            if (wb_valid) begin
                if (wb_q.size() == 0) begin
                    chk($sformatf("row%0d_wb_unexpected", r), 32'(wb_valid), 32'd0);
                end else begin
                    wb_exp = wb_q.pop_front();
                    chk($sformatf("row%0d_wb_data", r), wb_data, wb_exp);
                end
            end
            tick();
        end
        chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);

        // Reset in the middle of a full pipeline.
        drive_idle();
        id_valid = 1; ex_writes_rd = 1; alu_result = 32'h55;
        repeat (3) tick();
        chk("pre_reset_wb_valid", 32'(wb_valid), 32'd1);
        chk("pre_reset_wb_data", wb_data, 32'h55);
        stall = 1;
        tick();
        rst = 0;
        tick();
        rst = 1;
        stall = 0;
        fwd_ex_ex1 = 1; fwd_mem_ex1 = 1; rs1_idx = 5; rf_rs1_data = 32'hABC;
        #1;
        chk("post_reset_wb_valid", 32'(wb_valid), 32'd0);
        chk("post_reset_ex_valid", 32'(ex_valid), 32'd0);
        chk("post_reset_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("post_reset_fwd_cnt", 32'(fwd_cnt), 32'd0);
        chk("post_reset_op1_rf", op1, 32'hABC);
        tick();
        chk("release1_wb_valid", 32'(wb_valid), 32'd0);
        chk("release1_op1_rf", op1, 32'hABC);
        tick();
        chk("release2_wb_valid", 32'(wb_valid), 32'd0);
        chk("release2_op1_exmem", op1, 32'h55);
        tick();
        chk("release3_wb_valid", 32'(wb_valid), 32'd1);
        chk("release3_fwd_cnt", 32'(fwd_cnt), 32'd1);

        // Counters must stick at all-ones.
        repeat (8) tick();
        chk("fwd_cnt_saturated", 32'(fwd_cnt), 32'd7);
        stall = 1;
        repeat (9) tick();
        chk("stall_cnt_saturated", 32'(stall_cnt), 32'd7);
        chk("fwd_cnt_held", 32'(fwd_cnt), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
